// File: rtl/mac_pkg.sv
// Shared definitions for the dual-MAC datapath and its output packer.
//   ACC_W        : accumulator result width used by the MAC units
//   BYTE_W       : width of one output beat
//   pack_state_e : packer FSM states
//   nbytes()     : number of whole bytes needed to carry a w-bit value
package mac_pkg;

  localparam int unsigned ACC_W  = 21;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } pack_state_e;

  function automatic int unsigned nbytes(input int unsigned w);
    return (w + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/mac_result_packer.sv
// Full-width MAC result packer.
//
// Captures one accumulated result over a valid/ready handshake and streams it out MSB-first as
// a sequence of bytes on a valid/ready port. One sample is held in flight; the next one loads
// in the same cycle the final beat is accepted, so back-to-back samples have no bubble.
//
// Optional build macro: MAC_PACK_CHECKSUM_EN -- appends one beat carrying the XOR of all data
// bytes; out_last then marks only that checksum beat.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   in_data holds a result
//   in_ready   packer accepts in_data this cycle
//   in_data    unsigned accumulated result, IN_W bits
//   out_valid  out_data/out_last are valid
//   out_ready  sink accepts the current beat
//   out_data   current byte
//   out_last   final beat of the sample
//   sample_cnt completed samples, wraps 255 -> 0
module mac_result_packer
  import mac_pkg::*;
#(
  parameter int unsigned IN_W   = ACC_W,
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        sample_cnt
);

  localparam int unsigned NBYTES = nbytes(IN_W);
  localparam int unsigned SHW    = NBYTES * BYTE_W;
`ifdef MAC_PACK_CHECKSUM_EN
  localparam int unsigned NBEATS = NBYTES + 1;
`else
  localparam int unsigned NBEATS = NBYTES;
`endif
  localparam logic [2:0] LastBeat = 3'(NBEATS - 1);

  pack_state_e       state_q, state_d;
  logic [SHW-1:0]    shreg_q, shreg_d;
  logic [2:0]        beat_q, beat_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] cur_byte;
  logic              is_send;
  logic              is_last;
  logic              load;

  assign cur_byte = shreg_q[SHW-1 -: BYTE_W];
  assign is_send  = (state_q == StSend);
  assign is_last  = is_send && (beat_q == LastBeat);

`ifdef MAC_PACK_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef MAC_PACK_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (!is_last) begin
            shreg_d = shreg_q << BYTE_W;
            beat_d  = beat_q + 3'd1;
`ifdef MAC_PACK_CHECKSUM_EN
            // Fold each data byte in as it leaves; the checksum beat itself is never folded.
            csum_d  = csum_q ^ cur_byte;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
            // Reload straight from the final beat so back-to-back samples see no idle cycle.
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shreg_d = SHW'(in_data);
      beat_d  = '0;
`ifdef MAC_PACK_CHECKSUM_EN
      csum_d  = '0;
`endif
    end
  end

  // Ready depends only on state and out_ready, never on in_valid.
  assign in_ready   = (state_q == StIdle) || (is_last && out_ready);
  assign out_valid  = is_send;
  assign out_last   = is_last;
  assign sample_cnt = cnt_q;

`ifdef MAC_PACK_CHECKSUM_EN
  assign out_data = !is_send ? '0 : (is_last ? csum_q : cur_byte);
`else
  assign out_data = is_send ? cur_byte : '0;
`endif

endmodule

// File: tb/tb_mac_result_packer.sv
module tb_mac_result_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [7:0]  sample_cnt;

  int total  = 0;
  int passed = 0;

`ifdef MAC_PACK_CHECKSUM_EN
  localparam int Beats = 4;
`else
  localparam int Beats = 3;
`endif

  mac_result_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sample_cnt(sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the beat currently presented (out_ready assumed 1), then advances one cycle.
  task automatic check_beat(input string tag, input logic [7:0] d, input logic last);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_ready"}, 32'(in_ready), 32'(last));
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single sample
    in_valid  = 1'b1;
    in_data   = 21'h1ABCDE;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("s1_b0", 8'h1A, 1'b0);
    check_beat("s1_b1", 8'hBC, 1'b0);
`ifdef MAC_PACK_CHECKSUM_EN
    check_beat("s1_b2", 8'hDE, 1'b0);
    check_beat("s1_ck", 8'h78, 1'b1);
`else
    check_beat("s1_b2", 8'hDE, 1'b1);
`endif
    chk("s1_idle_valid", 32'(out_valid), 32'd0);
    chk("s1_cnt", 32'(sample_cnt), 32'd1);
    chk("s1_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back, in_valid held throughout the first sample
    in_valid = 1'b1;
    in_data  = 21'h000001;
    tick();
    check_beat("bb_a0", 8'h00, 1'b0);
    check_beat("bb_a1", 8'h00, 1'b0);
    in_data = 21'h1FFFFF;
`ifdef MAC_PACK_CHECKSUM_EN
    check_beat("bb_a2", 8'h01, 1'b0);
    check_beat("bb_ack", 8'h01, 1'b1);
`else
    check_beat("bb_a2", 8'h01, 1'b1);
`endif
    in_valid = 1'b0;
    check_beat("bb_b0", 8'h1F, 1'b0);
    check_beat("bb_b1", 8'hFF, 1'b0);
`ifdef MAC_PACK_CHECKSUM_EN
    check_beat("bb_b2", 8'hFF, 1'b0);
    check_beat("bb_bck", 8'h1F, 1'b1);
`else
    check_beat("bb_b2", 8'hFF, 1'b1);
`endif
    chk("bb_cnt", 32'(sample_cnt), 32'd3);
    chk("bb_idle_valid", 32'(out_valid), 32'd0);

    // Backpressure on beat 2
    in_valid = 1'b1;
    in_data  = 21'h123456;
    tick();
    in_valid = 1'b0;
    check_beat("bp_b0", 8'h12, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h34);
      chk("bp_hold_last", 32'(out_last), 32'd0);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    check_beat("bp_b1", 8'h34, 1'b0);
`ifdef MAC_PACK_CHECKSUM_EN
    check_beat("bp_b2", 8'h56, 1'b0);
    check_beat("bp_ck", 8'h70, 1'b1);
`else
    check_beat("bp_b2", 8'h56, 1'b1);
`endif
    chk("bp_cnt", 32'(sample_cnt), 32'd4);

    // Reset mid-frame
    in_valid = 1'b1;
    in_data  = 21'h0ABCDE;
    tick();
    in_valid = 1'b0;
    check_beat("rm_b0", 8'h0A, 1'b0);
    rst = 1'b1;
    #1;
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_data", 32'(out_data), 32'd0);
    chk("rm_cnt", 32'(sample_cnt), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 21'h000042;
    tick();
    in_valid = 1'b0;
    check_beat("rm_n0", 8'h00, 1'b0);
    check_beat("rm_n1", 8'h00, 1'b0);
`ifdef MAC_PACK_CHECKSUM_EN
    check_beat("rm_n2", 8'h42, 1'b0);
    check_beat("rm_nck", 8'h42, 1'b1);
`else
    check_beat("rm_n2", 8'h42, 1'b1);
`endif
    chk("rm_cnt_after", 32'(sample_cnt), 32'd1);

    // Counter wrap: 256 back-to-back zero samples from a clean reset
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = '0;
    tick();
    for (int i = 0; i < 256 * Beats - 1; i++) begin
      tick();
    end
    chk("wrap_last", 32'(out_last), 32'd1);
    chk("wrap_cnt_255", 32'(sample_cnt), 32'd255);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt_0", 32'(sample_cnt), 32'd0);
    chk("wrap_idle_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
